// File: rtl/note_pkg.sv
// note_pkg: shared widths, codes and FSM encodings for the note recorder.
//   PITCH_W     pitch code width
//   NUM_KEYS    playable keys (pitches 0..NUM_KEYS-1)
//   REST_PITCH  rest / idle pitch code; lands off-screen downstream
//   EV_DUR_W    default duration width
//   note_event_t  stored event layout {pitch, dur} for the default width
//   ST_*        FSM state encodings
package note_pkg;

   localparam int PITCH_W  = 6;
   localparam int NUM_KEYS = 48;
   localparam int EV_DUR_W = 8;

   localparam logic [PITCH_W-1:0] REST_PITCH = 6'd63;

   typedef struct packed {
      logic [PITCH_W-1:0]  pitch;
      logic [EV_DUR_W-1:0] dur;
   } note_event_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RECORD = 2'd1;
   localparam logic [1:0] ST_PLAY   = 2'd2;

endpackage

// File: rtl/note_event_ram.sv
// note_event_ram: DEPTH x W event store, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk    system clock
//   we     write enable
//   waddr  write address
//   wdata  write data {pitch, dur}
//   raddr  read address
//   rdata  read data (combinational)
module note_event_ram #(
   parameter int DEPTH = 64,
   parameter int W     = 14
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/note_recorder.sv
// note_recorder: records held keys as (pitch, duration) events counted in
// ticks and replays them as a registered pitch stream.
//   clk, rst            clock, synchronous active-high reset
//   tick                one-cycle time-base pulse
//   key_valid/key_pitch held key
//   start_rec/start_play/stop  command pulses (stop > start_rec > start_play)
//   out_pitch/out_valid playback pitch (63 = rest/idle), valid non-rest
//   busy_rec/busy_play  state flags
//   full                sticky: last recording filled the RAM
//   ev_count            stored events
//   play_done           one-cycle end-of-playback pulse
// Build option: NOTE_RECORDER_LOOP_EN makes playback wrap until stop.
//
// state     | meaning
// ST_IDLE   | waiting for a command, out_pitch = rest
// ST_RECORD | sampling keys on each tick, building events
// ST_PLAY   | stepping through stored events on each tick
module note_recorder
   import note_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int DUR_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     key_valid,
   input  logic [5:0]               key_pitch,
   input  logic                     start_rec,
   input  logic                     start_play,
   input  logic                     stop,
   output logic [5:0]               out_pitch,
   output logic                     out_valid,
   output logic                     busy_rec,
   output logic                     busy_play,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     play_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = PITCH_W + DUR_W;
   localparam logic [DUR_W-1:0] DUR_MAX   = '1;
   localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
   localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(DEPTH);

   logic [1:0]         state;
   logic [PITCH_W-1:0] cur;
   logic [DUR_W-1:0]   dur;
   logic               cur_valid;
   logic [AW:0]        idx;
   logic [DUR_W-1:0]   remain;

   logic [PITCH_W-1:0] samp;
   logic               we;
   logic [AW-1:0]      raddr;
   logic [EW-1:0]      rdata;
   logic [AW:0]        idx_nxt;
   logic [AW:0]        cnt_nxt;
   logic [PITCH_W-1:0] rd_pitch;
   logic [DUR_W-1:0]   rd_dur;

   assign samp     = key_valid ? key_pitch : REST_PITCH;
   assign idx_nxt  = idx + 1'b1;
   assign cnt_nxt  = ev_count + 1'b1;
   assign rd_pitch = rdata[EW-1:DUR_W];
   assign rd_dur   = rdata[DUR_W-1:0];

   // A write closes the current event: on stop (flush) or when the sample
   // breaks the run, including a run that has reached DUR_MAX.
   always_comb begin
      we = 1'b0;
      if (state == ST_RECORD) begin
         if (stop)
            we = cur_valid;
         else if (tick && cur_valid && !(samp == cur && dur != DUR_MAX))
            we = 1'b1;
      end
   end

   // Read port pre-addresses whatever event is loaded next: slot 0 from IDLE
   // and at the end of a take (wrap), otherwise the event after idx.
   assign raddr = (state == ST_PLAY && idx_nxt != ev_count) ? idx_nxt[AW-1:0] : '0;

   note_event_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (ev_count[AW-1:0]),
      .wdata ({cur, dur}),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cur       <= REST_PITCH;
         dur       <= '0;
         cur_valid <= 1'b0;
         ev_count  <= '0;
         full      <= 1'b0;
         idx       <= '0;
         remain    <= '0;
         out_pitch <= REST_PITCH;
         play_done <= 1'b0;
      end else begin
         play_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (stop) begin
                  // stop outranks the start pulses even when idle
               end else if (start_rec) begin
                  state     <= ST_RECORD;
                  ev_count  <= '0;
                  full      <= 1'b0;
                  cur_valid <= 1'b0;
               end else if (start_play) begin
                  if (ev_count == '0) begin
                     play_done <= 1'b1;
                  end else begin
                     state     <= ST_PLAY;
                     idx       <= '0;
                     out_pitch <= rd_pitch;
                     remain    <= rd_dur;
                  end
               end
            end
            ST_RECORD: begin
               if (stop) begin
                  if (cur_valid) begin
                     ev_count <= cnt_nxt;
                     if (cnt_nxt == DEPTH_CNT) full <= 1'b1;
                  end
                  cur_valid <= 1'b0;
                  state     <= ST_IDLE;
               end else if (tick) begin
                  if (!cur_valid) begin
                     cur       <= samp;
                     dur       <= DUR_ONE;
                     cur_valid <= 1'b1;
                  end else if (samp == cur && dur != DUR_MAX) begin
                     dur <= dur + 1'b1;
                  end else begin
                     ev_count <= cnt_nxt;
                     if (cnt_nxt == DEPTH_CNT) begin
                        full      <= 1'b1;
                        cur_valid <= 1'b0;
                        state     <= ST_IDLE;
                     end else begin
                        cur <= samp;
                        dur <= DUR_ONE;
                     end
                  end
               end
            end
            ST_PLAY: begin
               if (stop) begin
                  out_pitch <= REST_PITCH;
                  state     <= ST_IDLE;
               end else if (tick) begin
                  if (remain != DUR_ONE) begin
                     remain <= remain - 1'b1;
                  end else if (idx_nxt == ev_count) begin
                     play_done <= 1'b1;
`ifdef NOTE_RECORDER_LOOP_EN
                     idx       <= '0;
                     out_pitch <= rd_pitch;
                     remain    <= rd_dur;
`else
                     out_pitch <= REST_PITCH;
                     state     <= ST_IDLE;
`endif
                  end else begin
                     idx       <= idx_nxt;
                     out_pitch <= rd_pitch;
                     remain    <= rd_dur;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy_rec  = (state == ST_RECORD);
   assign busy_play = (state == ST_PLAY);
   assign out_valid = busy_play && (out_pitch != REST_PITCH);

endmodule
